// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates I-cache line fills and D-cache fills/writebacks onto
//            a single physical-memory port (IDLE/SERVE_I/SERVE_D/DONE FSM).
//            Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention
//            (otherwise the D-cache always wins).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic                  icache_pmem_resp,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic                  dcache_pmem_resp,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SERVE_I = 2'd1;
    localparam logic [1:0] S_SERVE_D = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_grant_d;

    assign w_i_req = icache_pmem_read;
    assign w_d_req = dcache_pmem_read | dcache_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the D-cache was the last side to enter service; reset means I-cache
    logic r_last_grant_d;

    // Record which side enters service whenever IDLE hands out a grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant_d <= 1'b0;
        end else if (r_state == S_IDLE && (w_i_req || w_d_req)) begin
            r_last_grant_d <= w_grant_d;
        end
    end

    // On contention the side that did not go last is granted
    assign w_grant_d = w_d_req && (!w_i_req || !r_last_grant_d);
`else
    // D-cache wins every contention
    assign w_grant_d = w_d_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; responses outside a SERVE state are simply ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = S_SERVE_D;
                end else if (w_i_req) begin
                    w_next_state = S_SERVE_I;
                end
            end
            S_SERVE_I: if (pmem_resp) w_next_state = S_DONE;
            S_SERVE_D: if (pmem_resp) w_next_state = S_DONE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is asserted
    always_comb begin
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address     = '0;
        pmem_wdata       = '0;
        icache_pmem_resp = 1'b0;
        dcache_pmem_resp = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_SERVE_I: begin
                    pmem_read        = 1'b1;
                    pmem_address     = icache_pmem_address;
                    icache_pmem_resp = pmem_resp;
                end
                S_SERVE_D: begin
                    // A writeback takes priority over a fill if both are raised
                    pmem_write       = dcache_pmem_write;
                    pmem_read        = dcache_pmem_read & ~dcache_pmem_write;
                    pmem_address     = dcache_pmem_address;
                    pmem_wdata       = dcache_pmem_wdata;
                    dcache_pmem_resp = pmem_resp;
                end
                default: begin
                end
            endcase
        end
    end

    // Fill data goes to both caches; only the resp pulse qualifies it
    assign icache_pmem_rdata = rst_n ? pmem_rdata : '0;
    assign dcache_pmem_rdata = rst_n ? pmem_rdata : '0;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the physical address width in bits.
REQ-002 Parameter LINE_WIDTH, default 128, sets the cache line width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 icache_pmem_read  input  1  I-cache line-fill request, held until its resp.
REQ-006 icache_pmem_address  input  ADDR_WIDTH  I-cache line address.
REQ-007 icache_pmem_resp  output  1  I-cache request completed, one-cycle pulse.
REQ-008 icache_pmem_rdata  output  LINE_WIDTH  I-cache fill data, valid with icache_pmem_resp.
REQ-009 dcache_pmem_read  input  1  D-cache line-fill request, held until its resp.
REQ-010 dcache_pmem_write  input  1  D-cache writeback request, held until its resp.
REQ-011 dcache_pmem_address  input  ADDR_WIDTH  D-cache line address.
REQ-012 dcache_pmem_wdata  input  LINE_WIDTH  D-cache writeback data.
REQ-013 dcache_pmem_resp  output  1  D-cache request completed, one-cycle pulse.
REQ-014 dcache_pmem_rdata  output  LINE_WIDTH  D-cache fill data, valid with dcache_pmem_resp.
REQ-015 pmem_read  output  1  physical memory read strobe.
REQ-016 pmem_write  output  1  physical memory write strobe.
REQ-017 pmem_address  output  ADDR_WIDTH  physical memory line address.
REQ-018 pmem_wdata  output  LINE_WIDTH  physical memory write data.
REQ-019 pmem_resp  input  1  physical memory done, one-cycle pulse.
REQ-020 pmem_rdata  input  LINE_WIDTH  physical memory read data, valid with pmem_resp.

Function
REQ-021 The FSM SHALL have states IDLE, SERVE_I, SERVE_D and DONE.
- IDLE: no pmem strobes.
- I request only -> SERVE_I.
- D request only -> SERVE_D.
- Both requesting -> per REQ-030.
REQ-022 In SERVE_I the block SHALL drive pmem_read=1 and pmem_write=0, with pmem_address=icache_pmem_address; pmem_wdata SHALL be 0.
REQ-023 In SERVE_D the block SHALL drive pmem_read/pmem_write, pmem_address and pmem_wdata from the D-cache inputs.
- If dcache_pmem_read and dcache_pmem_write are both high, write SHALL win: pmem_write=1, pmem_read=0.
REQ-024 pmem_resp in a SERVE state SHALL be forwarded combinationally, same cycle, to the granted side's resp only, and the FSM SHALL go to DONE.
REQ-025 The non-granted side's resp SHALL remain 0 throughout.
REQ-026 DONE SHALL last exactly one cycle with all pmem strobes low, then return to IDLE.
- Re-arbitration occurs in the following IDLE cycle; minimum spacing between pmem transactions is two idle cycles.
REQ-027 icache_pmem_rdata and dcache_pmem_rdata SHALL both equal pmem_rdata at all times.
- Only the resp qualifies the data.
REQ-028 Grant SHALL hold until pmem_resp even if the granted requester deasserts mid-service (protocol violation).
- pmem strobes SHALL remain as last driven by the granted side's current inputs.
REQ-029 pmem_resp received in IDLE or DONE SHALL be ignored: no resp forwarded, no state change.
REQ-030 Contention policy SHALL be set by ARB_ROUND_ROBIN_EN (see Configuration).
REQ-031 Request-to-pmem-strobe latency SHALL be one cycle: request sampled in IDLE, strobe asserted in the following SERVE cycle.

Reset
REQ-032 rst_n low at a rising edge SHALL force state IDLE and last_grant=I, including mid-transaction.
- The in-flight transaction is abandoned.
- Any later pmem_resp for it is ignored per REQ-029.
REQ-033 While in reset, all outputs SHALL be 0.

Configuration
REQ-034 ARB_ROUND_ROBIN_EN defined:
- A last_grant register SHALL record the side entering SERVE.
- On contention in IDLE, the side not equal to last_grant SHALL be granted.
REQ-035 ARB_ROUND_ROBIN_EN undefined:
- D-cache SHALL always win contention.
- No last_grant register SHALL exist.

Verification
REQ-036 I read addr 0x1230 alone, pmem_resp after 3 cycles with rdata 0xA5..A5 -> pmem_read=1, pmem_address=0x1230; icache_pmem_resp pulses with rdata 0xA5..A5; dcache_pmem_resp stays 0.
REQ-037 D write addr 0x4560 with wdata 0x1111..11 -> pmem_write=1, pmem_wdata=0x1111..11; dcache_pmem_resp one cycle; FSM passes through DONE, then IDLE.
REQ-038 I and D requests asserted in the same cycle, repeatedly for 4 transactions:
- With macro: grants go D,I,D,I.
- Without macro: grants go D,D,D,D.
REQ-039 D read and write both high -> pmem_write=1 and pmem_read=0.
REQ-040 rst_n low for 1 cycle during SERVE_I, then pmem_resp arrives -> all outputs 0 during reset; stray resp ignored; next I request is served normally.
REQ-041 pmem_resp pulsed in IDLE with no requests -> no resp outputs asserted and state stays IDLE.
